// File: rtl/sha256_message_schedule_if.sv
// Bus bundle for the SHA-256 message schedule: block load, round advance and W[t] output.
// SCHED_WK_SUM_EN adds the wk_out (W[t] + K[t]) signal.
interface sha256_message_schedule_if;
    logic         load;
    logic [511:0] block_in;
    logic         advance;
    logic [31:0]  w_out;
    logic         w_valid;
    logic [5:0]   round_idx;
    logic         done;
`ifdef SCHED_WK_SUM_EN
    logic [31:0]  wk_out;
`endif

`ifdef SCHED_WK_SUM_EN
    modport master (output load, block_in, advance,
                    input  w_out, w_valid, round_idx, done, wk_out);
    modport slave  (input  load, block_in, advance,
                    output w_out, w_valid, round_idx, done, wk_out);
`else
    modport master (output load, block_in, advance,
                    input  w_out, w_valid, round_idx, done);
    modport slave  (input  load, block_in, advance,
                    output w_out, w_valid, round_idx, done);
`endif
endinterface

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: 16-word sliding window producing W[0..63], one word per advance.
// SCHED_WK_SUM_EN adds a registered W[t] + K[t] output fed by an internal K ROM.
module sha256_message_schedule (
    input  logic                      clk,
    input  logic                      n_rst,
    sha256_message_schedule_if.slave  bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WIN_N  = 16;
    localparam int unsigned ROUNDS = 64;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned BLK_W  = WORD_W * WIN_N;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] win_q [WIN_N];
    logic [IDX_W-1:0]  idx_q;
    logic              w_valid_q, done_q;
    logic              w_valid_d, done_d;
    logic              step_c, shift_c;
    logic [WORD_W-1:0] new_word_c;

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; load wins over advance in every state
    always_comb begin
        state_d = state_q;
        if (bus.load)
            state_d = ST_RUN;
        else if (state_q == ST_RUN && bus.advance && idx_q == IDX_W'(ROUNDS - 1))
            state_d = ST_DONE;
    end

    // Output decode; flags are taken from the next state so they register alongside it
    always_comb begin
        w_valid_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
        step_c    = !bus.load && state_q == ST_RUN && bus.advance;
        shift_c   = step_c && idx_q != IDX_W'(ROUNDS - 1);
    end

    assign new_word_c = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            w_valid_q <= w_valid_d;
            done_q    <= done_d;
        end
    end

    // Window and round counter; the last advance does not shift so W[64] never appears
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(WIN_N); i++) win_q[i] <= '0;
            idx_q <= '0;
        end else if (bus.load) begin
            for (int i = 0; i < int'(WIN_N); i++)
                win_q[i] <= bus.block_in[WORD_W*(WIN_N-1-i) +: WORD_W];
            idx_q <= '0;
        end else if (step_c) begin
            idx_q <= idx_q + IDX_W'(1);
            if (shift_c) begin
                for (int i = 0; i < int'(WIN_N) - 1; i++) win_q[i] <= win_q[i+1];
                win_q[WIN_N-1] <= new_word_c;
            end
        end
    end

    assign bus.w_out     = win_q[0];
    assign bus.w_valid   = w_valid_q;
    assign bus.round_idx = idx_q;
    assign bus.done      = done_q;

`ifdef SCHED_WK_SUM_EN
    localparam logic [WORD_W-1:0] K_ROM [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [WORD_W-1:0] wk_q;

    // Sum tracks the word that lands in win[0] on the same edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            wk_q <= '0;
        else if (bus.load)
            wk_q <= bus.block_in[BLK_W-1 -: WORD_W] + K_ROM[0];
        else if (shift_c)
            wk_q <= win_q[1] + K_ROM[idx_q + IDX_W'(1)];
    end

    assign bus.wk_out = wk_q;
`endif
endmodule

// File: tb/tb_sha256_message_schedule.sv
// Directed bench for sha256_message_schedule: "abc" schedule, stalls, load priority, reset abort.
// Define SCHED_WK_SUM_EN for both DUT and bench to also check wk_out.
module tb_sha256_message_schedule;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sha256_message_schedule_if bus ();
    sha256_message_schedule dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [31:0]  exp_w [64];
    logic [511:0] abc_blk;
    logic [511:0] blk2;
    int t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule built straight from the SHA-256 recurrence
    task automatic build_sched(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[480 - 32*i +: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
                     + exp_w[i-7]
                     + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
                     + exp_w[i-16];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.w_valid), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_idx"},   32'(bus.round_idx), 32'd0);
        check({tag, "_w"},     bus.w_out, 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        bus.load = 1'b0;
        bus.advance = 1'b0;
        bus.block_in = '0;
        abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
        for (int i = 0; i < 16; i++) blk2[480 - 32*i +: 32] = 32'h01234567 ^ (32'(i) * 32'h11111111);

        #12;
        check_idle("rst");
`ifdef SCHED_WK_SUM_EN
        check("rst_wk", bus.wk_out, 32'd0);
`endif
        tick();
        n_rst = 1'b1;
        bus.advance = 1'b1;
        tick();
        check_idle("idle_adv");

        // Load "abc" and run with advance held high
        build_sched(abc_blk);
        bus.advance = 1'b0;
        bus.block_in = abc_blk;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("load_valid", 32'(bus.w_valid), 32'd1);
        check("load_idx", 32'(bus.round_idx), 32'd0);
        check("load_w0", bus.w_out, 32'h61626380);
        check("load_done", 32'(bus.done), 32'd0);
`ifdef SCHED_WK_SUM_EN
        check("wk_t0", bus.wk_out, 32'hA3EC9318);
`endif
        bus.advance = 1'b1;
        for (int k = 1; k < 64; k++) begin
            tick();
            check($sformatf("run_idx%0d", k), 32'(bus.round_idx), 32'(k));
            check($sformatf("run_w%0d", k), bus.w_out, exp_w[k]);
            check($sformatf("run_valid%0d", k), 32'(bus.w_valid), 32'd1);
            if (k == 16) check("abc_w16", bus.w_out, 32'h61626380);
            if (k == 17) check("abc_w17", bus.w_out, 32'h000F0000);
            if (k == 18) check("abc_w18", bus.w_out, 32'h7DA86405);
            if (k == 63) check("abc_w63", bus.w_out, 32'h12B1EDEB);
`ifdef SCHED_WK_SUM_EN
            if (k == 1) check("wk_t1", bus.wk_out, 32'h71374491);
`endif
        end
        tick();
        check("end_done", 32'(bus.done), 32'd1);
        check("end_valid", 32'(bus.w_valid), 32'd0);
        check("end_idx", 32'(bus.round_idx), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("done_adv_done", 32'(bus.done), 32'd1);
            check("done_adv_valid", 32'(bus.w_valid), 32'd0);
            check("done_adv_idx", 32'(bus.round_idx), 32'd0);
        end

        // Reload and stall randomly up to round 37
        bus.advance = 1'b0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("reload_w0", bus.w_out, exp_w[0]);
        t = 0;
        for (int it = 0; it < 2000 && t < 37; it++) begin
            bus.advance = 1'($urandom_range(0, 1));
            tick();
            if (bus.advance) t++;
            check("stall_idx", 32'(bus.round_idx), 32'(t));
            check("stall_w", bus.w_out, exp_w[t]);
        end
        check("stall_reach37", 32'(t), 32'd37);

        // Load and advance together: load wins
        build_sched(blk2);
        bus.block_in = blk2;
        bus.load = 1'b1;
        bus.advance = 1'b1;
        tick();
        bus.load = 1'b0;
        check("prio_idx", 32'(bus.round_idx), 32'd0);
        check("prio_w0", bus.w_out, exp_w[0]);
        check("prio_valid", 32'(bus.w_valid), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("blk2_w%0d", k), bus.w_out, exp_w[k]);
        end
        check("blk2_idx20", 32'(bus.round_idx), 32'd20);

        // Asynchronous reset in the middle of a cycle
        #2;
        n_rst = 1'b0;
        #1;
        check_idle("arst");
`ifdef SCHED_WK_SUM_EN
        check("arst_wk", bus.wk_out, 32'd0);
`endif
        #2;
        n_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("post_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
